// File: rtl/round_sequencer_pkg.sv
// round_sequencer_pkg: state codes, point values and sizing helper shared by the round sequencer
package round_sequencer_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INTRO = 3'd1,
    PLAY  = 3'd2,
    SAVE  = 3'd3,
    OVER  = 3'd4
  } state_t;
  localparam int SCORE_W_DEF = 8;
  localparam int PTS_TWO = 2;
  localparam int PTS_THREE = 3;
  function automatic int max_i(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/round_sequencer_if.sv
// round_sequencer_if: player/timer/save/display signals of the round sequencer
interface round_sequencer_if #(parameter int SCORE_W = 8);
  logic start_btn;
  logic frame_tick;
  logic timer_done;
  logic shot_valid;
  logic [1:0] shot_pts;
  logic save_ack;
  logic timer_go;
  logic save_req;
  logic [SCORE_W-1:0] save_score;
  logic [SCORE_W-1:0] score;
  logic [1:0] round_num;
  logic [1:0] intro_count;
  logic [2:0] state_o;
  modport master (
    input  start_btn, frame_tick, timer_done, shot_valid, shot_pts, save_ack,
    output timer_go, save_req, save_score, score, round_num, intro_count, state_o
  );
  modport slave (
    output start_btn, frame_tick, timer_done, shot_valid, shot_pts, save_ack,
    input  timer_go, save_req, save_score, score, round_num, intro_count, state_o
  );
endinterface

// File: rtl/round_sequencer_frame_delay_counter.sv
// round_sequencer_frame_delay_counter: saturating frame_tick counter with clear and terminal-count flag
module round_sequencer_frame_delay_counter #(parameter int CW = 9) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          tick,
  input  logic [CW-1:0] last,
  output logic [CW-1:0] cnt,
  output logic          done
);
  assign done = tick && cnt == last;
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (tick && cnt != '1) cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: game-round FSM driving intro countdown, timed rounds, score and high-score save
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int SCORE_W      = SCORE_W_DEF,
  parameter int ROUNDS       = 3,
  parameter int BONUS_STEP   = 30,
  parameter int INTRO_FRAMES = 180,
  parameter int OVER_FRAMES  = 300
) (
  input  logic clk,
  input  logic reset,
  round_sequencer_if.master bus
);
  localparam int CW = $clog2(max_i(INTRO_FRAMES, OVER_FRAMES));
  state_t state, nxt;
  logic start_q, start_rise, timer_go, advance, clr_game, tick, done, end_ok, can_adv;
  logic [1:0] play_cyc, round_num;
  logic [CW-1:0] cnt;
  logic [SCORE_W-1:0] score, score_n, save_score;
  logic [SCORE_W:0] sum;
  assign start_rise = bus.start_btn & ~start_q;
  assign sum = {1'b0, score} + {{(SCORE_W-1){1'b0}}, bus.shot_pts};
  assign score_n = !bus.shot_valid ? score : sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  assign tick = bus.frame_tick && (state == INTRO || state == OVER);
  // timer_done is stale for two cycles after timer_go while the timer clears
  assign end_ok = bus.timer_done && play_cyc == 2'd2;
  assign can_adv = 32'(round_num) < ROUNDS - 1 && 32'(score_n) >= BONUS_STEP * (32'(round_num) + 1);
  assign clr_game = nxt == IDLE || ((state == IDLE || state == OVER) && nxt == INTRO);
  round_sequencer_frame_delay_counter #(.CW(CW)) u_frames (
    .clk  (clk),
    .reset(reset),
    .clr  (nxt != state),
    .tick (tick),
    .last (state == INTRO ? CW'(INTRO_FRAMES - 1) : CW'(OVER_FRAMES - 1)),
    .cnt  (cnt),
    .done (done)
  );
  always_ff @(posedge clk) begin
    start_q <= bus.start_btn;
    if (reset) begin
      state <= IDLE;
      score <= '0;
      round_num <= '0;
      save_score <= '0;
      play_cyc <= '0;
    end else begin
      state <= nxt;
      score <= clr_game ? '0 : state == PLAY ? score_n : score;
      round_num <= clr_game ? '0 : advance ? round_num + 2'd1 : round_num;
      save_score <= (state == PLAY && nxt == SAVE) ? score_n : save_score;
      play_cyc <= state != PLAY ? '0 : play_cyc == 2'd2 ? play_cyc : play_cyc + 2'd1;
    end
  end
  always_comb begin
    nxt = state;
    timer_go = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE:  nxt = start_rise ? INTRO : IDLE;
      INTRO: begin
        timer_go = done;
        nxt = done ? PLAY : INTRO;
      end
      PLAY:  begin
        advance = end_ok && can_adv;
        nxt = !end_ok ? PLAY : can_adv ? INTRO : SAVE;
      end
      SAVE:  nxt = bus.save_ack ? OVER : SAVE;
      OVER:  nxt = start_rise ? INTRO : done ? IDLE : OVER;
      default: nxt = IDLE;
    endcase
  end
  assign bus.timer_go = timer_go;
  assign bus.save_req = state == SAVE;
  assign bus.save_score = save_score;
  assign bus.score = score;
  assign bus.round_num = round_num;
  assign bus.intro_count = state == INTRO ? 2'(3 - 32'(cnt) * 3 / INTRO_FRAMES) : 2'd0;
  assign bus.state_o = state;
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed game scenarios with a state-change scoreboard for round_sequencer
module tb_round_sequencer;
  typedef struct {int st; int sc; int rn; int sr; int ss;} ev_t;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];
  int prev_st = 0;
  int go_cnt = 0;
  logic [5:0] intro_seq = '0;
  round_sequencer_if #(.SCORE_W(8)) bus ();
  round_sequencer #(.SCORE_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic expect_ev(input int st, input int sc, input int rn, input int sr, input int ss);
    ev_t e;
    e = '{st, sc, rn, sr, ss};
    exp_q.push_back(e);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
    end
  endtask
  task automatic press();
    bus.start_btn = 1'b1;
    cyc();
    cyc();
    bus.start_btn = 1'b0;
    cyc();
  endtask
  task automatic shot(input int p);
    bus.shot_valid = 1'b1;
    bus.shot_pts = 2'(p);
    cyc();
    bus.shot_valid = 1'b0;
    bus.shot_pts = 2'd0;
  endtask
  task automatic td_pulse();
    bus.timer_done = 1'b1;
    cyc();
    bus.timer_done = 1'b0;
  endtask
  task automatic rst_pulse();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_save_req", int'(bus.save_req), 0);
    chk("rst_timer_go", int'(bus.timer_go), 0);
  endtask
  always @(negedge clk) begin
    ev_t e;
    if (int'(bus.state_o) != prev_st) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transition: got state %0d from %0d expected none", bus.state_o, prev_st);
      end else begin
        e = exp_q.pop_front();
        chk("ev_state", int'(bus.state_o), e.st);
        chk("ev_score", int'(bus.score), e.sc);
        chk("ev_round", int'(bus.round_num), e.rn);
        chk("ev_save_req", int'(bus.save_req), e.sr);
        chk("ev_save_score", int'(bus.save_score), e.ss);
      end
      chk("timer_go_cycles", go_cnt, (prev_st == 1 && int'(bus.state_o) == 2) ? 1 : 0);
      if (prev_st == 1 && int'(bus.state_o) == 2) chk("intro_digits", int'(intro_seq), 6'b11_10_01);
      go_cnt = 0;
      intro_seq = '0;
      prev_st = int'(bus.state_o);
    end
    go_cnt += int'(bus.timer_go);
    if (bus.state_o == 3'd1 && bus.intro_count != intro_seq[1:0]) intro_seq = {intro_seq[3:0], bus.intro_count};
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d events pending", exp_q.size());
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    bus.start_btn = 1'b1;
    bus.frame_tick = 1'b0;
    bus.timer_done = 1'b0;
    bus.shot_valid = 1'b0;
    bus.shot_pts = 2'd0;
    bus.save_ack = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (5) cyc();
    chk("reset_state", int'(bus.state_o), 0);
    chk("reset_score", int'(bus.score), 0);
    chk("reset_round", int'(bus.round_num), 0);
    chk("reset_save_req", int'(bus.save_req), 0);
    chk("reset_timer_go", int'(bus.timer_go), 0);
    chk("reset_intro_count", int'(bus.intro_count), 0);
    bus.start_btn = 1'b0;
    cyc();
    expect_ev(1, 0, 0, 0, 0);
    press();
    expect_ev(2, 0, 0, 0, 0);
    tick_n(180);
    cyc();
    cyc();
    shot(2);
    shot(3);
    shot(3);
    expect_ev(3, 8, 0, 1, 8);
    td_pulse();
    repeat (5) cyc();
    expect_ev(4, 8, 0, 0, 8);
    bus.save_ack = 1'b1;
    cyc();
    bus.save_ack = 1'b0;
    expect_ev(0, 0, 0, 0, 8);
    tick_n(300);
    cyc();
    expect_ev(1, 0, 0, 0, 8);
    press();
    expect_ev(2, 0, 0, 0, 8);
    tick_n(180);
    repeat (10) shot(3);
    expect_ev(1, 30, 1, 0, 8);
    td_pulse();
    expect_ev(2, 30, 1, 0, 8);
    tick_n(180);
    repeat (9) shot(3);
    shot(2);
    expect_ev(3, 59, 1, 1, 59);
    td_pulse();
    expect_ev(4, 59, 1, 0, 59);
    bus.save_ack = 1'b1;
    cyc();
    bus.save_ack = 1'b0;
    repeat (4) cyc();
    expect_ev(1, 0, 0, 0, 59);
    press();
    expect_ev(2, 0, 0, 0, 59);
    tick_n(180);
    repeat (84) shot(3);
    shot(2);
    expect_ev(1, 255, 1, 0, 59);
    bus.shot_valid = 1'b1;
    bus.shot_pts = 2'd3;
    bus.timer_done = 1'b1;
    cyc();
    bus.shot_valid = 1'b0;
    bus.shot_pts = 2'd0;
    bus.timer_done = 1'b0;
    expect_ev(2, 255, 1, 0, 59);
    tick_n(180);
    bus.timer_done = 1'b1;
    cyc();
    cyc();
    bus.timer_done = 1'b0;
    shot(2);
    expect_ev(1, 255, 2, 0, 59);
    td_pulse();
    expect_ev(2, 255, 2, 0, 59);
    tick_n(180);
    cyc();
    cyc();
    expect_ev(3, 255, 2, 1, 255);
    td_pulse();
    repeat (3) cyc();
    expect_ev(0, 0, 0, 0, 0);
    rst_pulse();
    cyc();
    expect_ev(1, 0, 0, 0, 0);
    press();
    expect_ev(2, 0, 0, 0, 0);
    tick_n(180);
    shot(3);
    cyc();
    expect_ev(0, 0, 0, 0, 0);
    rst_pulse();
    repeat (5) cyc();
    chk("events_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
